// File: rtl/serial_frame_tx.sv
// serial_frame_tx: 8N1 transmitter for a sync byte, a 32-bit word sent MSB byte first, and a checksum byte
module serial_frame_tx #(
  parameter int          CLK_HZ = 100000000,
  parameter int          BAUD   = 115200,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] data,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam int         BIT_TICKS = CLK_HZ / BAUD;
  localparam logic [15:0] LAST     = 16'(BIT_TICKS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [2:0]  bit_q, bit_d, byte_q, byte_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d, cur_byte;
  logic        tx_q, tx_d, done_q, done_d, bit_end;
  assign bit_end = (state_q != IDLE) && (tick_q == LAST);
  assign tx      = tx_q;
  assign busy    = state_q != IDLE;
  assign done    = done_q;
  // sequencing through start, data and stop bits of each of the six bytes
  always_comb begin
    state_d = state_q;
    tick_d  = (state_q == IDLE || bit_end) ? '0 : tick_q + 16'd1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (send) begin
        state_d = START;
        bit_d   = '0;
        byte_d  = '0;
        word_d  = data;
        csum_d  = data[31:24] + data[23:16] + data[15:8] + data[7:0];
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        if (bit_q == 3'd7) state_d = STOP;
        else bit_d = bit_q + 3'd1;
      end
      STOP: if (bit_end) begin
        if (byte_q == 3'd5) begin
          state_d = IDLE;
          byte_d  = '0;
          done_d  = 1'b1;
        end else begin
          state_d = START;
          byte_d  = byte_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // line level for the upcoming cycle, registered so tx never glitches
  always_comb begin
    cur_byte = byte_d == 3'd0 ? SYNC :
               byte_d == 3'd1 ? word_q[31:24] :
               byte_d == 3'd2 ? word_q[23:16] :
               byte_d == 3'd3 ? word_q[15:8] :
               byte_d == 3'd4 ? word_q[7:0] : csum_q;
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? cur_byte[bit_d] : 1'b1;
  end
  // state register; reset drops any frame in flight and idles the line high
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end
endmodule
